// File: rtl/fp_arith_pkg.sv
// Shared FP32 constants, arbiter FSM encoding and a saturating counter helper.
package fp_arith_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } arb_state_t;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = {1'b0, pointer} + (PW+1)'(off);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (!grant_valid && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                grant_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one FP32 multiplier among NUM_REQ requesters: round-robin, one op in flight, watchdog timeout.
// Optional completion counters (stat_ops/stat_nan/stat_tmo) when FP_MULT_ARB_STATS_EN is defined.
module fp_mult_arbiter
    import fp_arith_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_result,
    output logic                    resp_nan,
    output logic                    resp_err,
    output logic                    mul_en,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    input  logic [31:0]             mul_result,
    input  logic                    mul_ready,
`ifdef FP_MULT_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]   stat_ops,
    output logic [15:0]             stat_nan,
    output logic [15:0]             stat_tmo,
`endif
    input  logic                    mul_nan
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    arb_state_t         state_q, state_d;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      gidx_d, gidx_q;
    logic [NUM_REQ-1:0] gnt, grant_q;
    logic               gnt_vld;
    logic [WW-1:0]      wd_q;
    logic               wd_expire;
    logic [31:0]        res_q;
    logic               nan_q, err_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req         (req_valid),
        .pointer     (ptr_q),
        .grant       (gnt),
        .grant_valid (gnt_vld)
    );

    always_comb begin
        gidx_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gidx_d = PW'(i);
        end
    end

    // Counter advances after the check, so the error response lands TIMEOUT_CYCLES after ISSUE.
    assign wd_expire = (wd_q == WW'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid) state_d = ARB;
            ARB:     state_d = gnt_vld ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mul_ready || wd_expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        mul_en     = 1'b0;
        if (state_q == ARB && gnt_vld) req_ready  = gnt;
        if (state_q == RESP)           resp_valid = grant_q;
        if (state_q == ISSUE)          mul_en     = 1'b1;
    end

    assign resp_result = res_q;
    assign resp_nan    = nan_q;
    assign resp_err    = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            wd_q    <= '0;
            res_q   <= '0;
            nan_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ARB: if (gnt_vld) begin
                    grant_q <= gnt;
                    gidx_q  <= gidx_d;
                    mul_a   <= req_a[32*int'(gidx_d) +: 32];
                    mul_b   <= req_b[32*int'(gidx_d) +: 32];
                    ptr_q   <= (gidx_d == PW'(NUM_REQ - 1)) ? '0 : gidx_d + 1'b1;
                end
                ISSUE: wd_q <= '0;
                WAIT: begin
                    if (mul_ready) begin
                        res_q <= mul_result;
                        nan_q <= mul_nan;
                        err_q <= 1'b0;
                    end else if (wd_expire) begin
                        res_q <= FP32_QNAN;
                        nan_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FP_MULT_ARB_STATS_EN
    logic [15:0] ops_cnt [NUM_REQ];
    logic [15:0] nan_cnt, tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) ops_cnt[i] <= '0;
            nan_cnt <= '0;
            tmo_cnt <= '0;
        end else if (state_q == RESP) begin
            ops_cnt[gidx_q] <= sat_inc16(ops_cnt[gidx_q]);
            if (nan_q) nan_cnt <= sat_inc16(nan_cnt);
            if (err_q) tmo_cnt <= sat_inc16(tmo_cnt);
        end
    end

    always_comb begin
        stat_ops = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_ops[16*i +: 16] = ops_cnt[i];
    end

    assign stat_nan = nan_cnt;
    assign stat_tmo = tmo_cnt;
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter with a table-driven multiplier model.
module tb_fp_mult_arbiter;
    import fp_arith_pkg::*;

    localparam int NR  = 4;
    localparam int TMO = 16;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*32-1:0] req_a = '0;
    logic [NR*32-1:0] req_b = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   resp_valid;
    logic [31:0]     resp_result;
    logic            resp_nan;
    logic            resp_err;
    logic            mul_en;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_result = '0;
    logic            mul_ready = 1'b0;
    logic            mul_nan = 1'b0;

    fp_mult_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_nan    (resp_nan),
        .resp_err    (resp_err),
        .mul_en      (mul_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_result  (mul_result),
        .mul_ready   (mul_ready),
        .mul_nan     (mul_nan)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        nan;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          en_count = 0;
    int          en_cyc = 0;
    int          late_req = 0;
    int          late_done = 0;
    logic        hold = 1'b0;
    logic        busy = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] cap_a = '0;
    logic [31:0] cap_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [32:0] mul_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h4000_0000, 32'h4040_0000}: return {1'b0, 32'h40C0_0000};
            {32'h3FC0_0000, 32'h3FC0_0000}: return {1'b0, 32'h4010_0000};
            {32'h3F80_0000, 32'h4000_0000}: return {1'b0, 32'h4000_0000};
            {32'h7F80_0000, 32'h0000_0000}: return {1'b1, 32'h7FC0_0000};
            default:                        return {1'b0, 32'hDEAD_BEEF};
        endcase
    endfunction

    task automatic model_loop();
        logic [32:0] r;
        forever begin
            @(posedge clk);
            #1;
            mul_ready = 1'b0;
            mul_nan   = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (lat_cnt == 0) begin
                        r = mul_lut(cap_a, cap_b);
                        mul_ready  = 1'b1;
                        mul_result = r[31:0];
                        mul_nan    = r[32];
                        busy       = 1'b0;
                        chk("mul_a_stable", mul_a, cap_a);
                        chk("mul_b_stable", mul_b, cap_b);
                    end else begin
                        lat_cnt--;
                    end
                end else if (late_req != late_done) begin
                    mul_ready  = 1'b1;
                    mul_result = 32'h1234_5678;
                    mul_nan    = 1'b1;
                    late_done++;
                end
                if (mul_en) begin
                    en_count++;
                    en_cyc = cyc;
                    cap_a  = mul_a;
                    cap_b  = mul_b;
                    if (!hold) begin
                        busy    = 1'b1;
                        lat_cnt = LAT - 1;
                    end
                end
            end
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_valid_sel", 32'(resp_valid), 32'(1) << e.idx);
                    chk("resp_result", resp_result, e.res);
                    chk("resp_nan", 32'(resp_nan), 32'(e.nan));
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    if (e.err) chk("tmo_latency", 32'(cyc - en_cyc), 32'(TMO));
                end
            end
        end
    endtask

    task automatic expect_resp(input int idx, input logic [31:0] res, input logic nan, input logic err);
        exp_t e;
        e.idx = idx;
        e.res = res;
        e.nan = nan;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Requesters hold valid until their own req_ready has been seen across a rising edge.
    task automatic launch(input logic [NR-1:0] mask);
        int          guard;
        logic [NR-1:0] hit;
        guard     = 0;
        req_valid = mask;
        while (req_valid != '0 && guard < 400) begin
            @(negedge clk);
            hit = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~hit;
            guard++;
        end
        chk("launch_granted", 32'(req_valid), 32'd0);
        req_valid = '0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_mul_en"},     32'(mul_en), 32'd0);
        chk({tag, "_mul_a"},      mul_a, 32'd0);
        chk({tag, "_mul_b"},      mul_b, 32'd0);
        chk({tag, "_resp_result"}, resp_result, 32'd0);
        chk({tag, "_resp_nan"},   32'(resp_nan), 32'd0);
        chk({tag, "_resp_err"},   32'(resp_err), 32'd0);
    endtask

    initial begin
        int e0;
        fork
            model_loop();
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // All four at once from pointer 0: served 0,1,2,3.
        for (int i = 0; i < NR; i++) begin
            set_op(i, 32'h3FC0_0000, 32'h3FC0_0000);
            expect_resp(i, 32'h4010_0000, 1'b0, 1'b0);
        end
        e0 = en_count;
        launch(4'b1111);
        drain();
        chk("en_count_4req", 32'(en_count - e0), 32'd4);

        // Single requester: 2.0 * 3.0.
        set_op(0, 32'h4000_0000, 32'h4040_0000);
        expect_resp(0, 32'h40C0_0000, 1'b0, 1'b0);
        e0 = en_count;
        launch(4'b0001);
        drain();
        chk("en_count_1req", 32'(en_count - e0), 32'd1);

        // Move pointer to 2 via req1, then req0+req3 must go 3 then 0.
        set_op(1, FP32_ONE, 32'h4000_0000);
        expect_resp(1, 32'h4000_0000, 1'b0, 1'b0);
        launch(4'b0010);
        drain();
        set_op(0, 32'h4000_0000, 32'h4040_0000);
        set_op(3, 32'h3FC0_0000, 32'h3FC0_0000);
        expect_resp(3, 32'h4010_0000, 1'b0, 1'b0);
        expect_resp(0, 32'h40C0_0000, 1'b0, 1'b0);
        launch(4'b1001);
        drain();

        // Inf * 0 gives a flagged quiet NaN.
        set_op(2, FP32_POS_INF, 32'h0000_0000);
        expect_resp(2, FP32_QNAN, 1'b1, 1'b0);
        launch(4'b0100);
        drain();

        // Stalled multiplier: watchdog completion, then a stray late ready, then a normal op.
        hold = 1'b1;
        set_op(3, FP32_ONE, 32'h4000_0000);
        expect_resp(3, FP32_QNAN, 1'b0, 1'b1);
        launch(4'b1000);
        drain();
        hold = 1'b0;
        late_req++;
        repeat (4) @(negedge clk);
        set_op(0, 32'h4000_0000, 32'h4040_0000);
        expect_resp(0, 32'h40C0_0000, 1'b0, 1'b0);
        launch(4'b0001);
        drain();

        // Reset during WAIT: no response, pointer back to 0 so req1 beats req3.
        hold = 1'b1;
        set_op(1, FP32_ONE, 32'h4000_0000);
        launch(4'b0010);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold  = 1'b0;
        check_idle_outputs("midop_reset");
        set_op(1, FP32_ONE, 32'h4000_0000);
        set_op(3, 32'h3FC0_0000, 32'h3FC0_0000);
        expect_resp(1, 32'h4000_0000, 1'b0, 1'b0);
        expect_resp(3, 32'h4010_0000, 1'b0, 1'b0);
        launch(4'b1010);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach the end (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
